clock_hms: RTL and testbench



---
 rtl/clock_pkg.sv | 27 ++
 rtl/bcd_mod_cnt.sv | 66 ++++++
 rtl/clock_hms.sv | 172 +++++++++++++++++
 tb/tb_clock_hms.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and 7-segment helpers for the HH:MM:SS wall clock.
package clock_pkg;

  typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, SET_AHR, SET_AMIN} mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g..a}; anything outside 0..9, or blank requested, turns all segments off.
  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return blank ? SEG_BLANK : s;
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter: counts MIN_VAL..MAX_TENS*10+MAX_ONES and wraps back to MIN_VAL.
module bcd_mod_cnt #(
  parameter int unsigned MAX_TENS = 5,
  parameter int unsigned MAX_ONES = 9,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned RST_VAL  = MIN_VAL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       cen,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] next_tens,
  output logic [3:0] next_ones,
  output logic       carry
);

  localparam logic [3:0] MaxTens = 4'(MAX_TENS);
  localparam logic [3:0] MaxOnes = 4'(MAX_ONES);
  localparam logic [3:0] MinTens = 4'(MIN_VAL / 10);
  localparam logic [3:0] MinOnes = 4'(MIN_VAL % 10);
  localparam logic [3:0] RstTens = 4'(RST_VAL / 10);
  localparam logic [3:0] RstOnes = 4'(RST_VAL % 10);

  logic [3:0] tens_q, ones_q;
  logic       at_max;

  assign at_max = (tens_q == MaxTens) && (ones_q == MaxOnes);
  // cen low gives the set-mode behaviour: wrap without carrying into the next field.
  assign carry  = inc & cen & at_max & ~clr;

  always_comb begin
    next_tens = tens_q;
    next_ones = ones_q;
    if (clr) begin
      next_tens = RstTens;
      next_ones = RstOnes;
    end else if (inc) begin
      if (at_max) begin
        next_tens = MinTens;
        next_ones = MinOnes;
      end else if (ones_q == 4'd9) begin
        next_tens = tens_q + 4'd1;
        next_ones = 4'd0;
      end else begin
        next_ones = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= RstTens;
      ones_q <= RstOnes;
    end else begin
      tens_q <= next_tens;
      ones_q <= next_ones;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/clock_hms.sv
// HH:MM:SS wall clock with per-field set mode, blinking and 12/24-h hours.
// Define CLOCK_ALARM_EN to add the alarm time registers, SET_AHR/SET_AMIN and the alarm output.
module clock_hms
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned H24       = 1,
  parameter int unsigned ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       pm,
  output logic       alarm
);

  localparam int unsigned    PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PresTop  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]  PresHalf = PW'(CLK_HZ / 2);
  localparam int unsigned    HrMaxT   = (H24 != 0) ? 2 : 1;
  localparam int unsigned    HrMaxO   = (H24 != 0) ? 3 : 2;
  localparam int unsigned    HrMin    = (H24 != 0) ? 0 : 1;
  localparam int unsigned    HrRst    = (H24 != 0) ? 0 : 12;

  mode_e         mode_q;
  logic [PW-1:0] presc_q;
  logic          pm_q;
  logic          tick, run, last_set, leave_set, blink;
  logic          sec_inc, min_inc, hr_inc, sec_carry, min_carry, hr_carry;
  logic [3:0]    sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;
  logic [3:0]    sec_ntens, sec_nones, min_ntens, min_nones, hr_ntens, hr_nones;

  assign tick = (presc_q == PresTop);
  assign run  = (mode_q == RUN);

`ifdef CLOCK_ALARM_EN
  assign last_set = (mode_q == SET_AMIN);
`else
  assign last_set = (mode_q == SET_SEC);
`endif
  assign leave_set = btn_mode & last_set & ~btn_clr;

  // Restarting the prescaler on exit gives a full second before the first tick.
  always_ff @(posedge clk) begin
    if (rst || btn_clr || leave_set || tick) presc_q <= '0;
    else                                     presc_q <= presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= RUN;
    end else if (btn_mode && !btn_clr) begin
      case (mode_q)
        RUN:      mode_q <= SET_HR;
        SET_HR:   mode_q <= SET_MIN;
        SET_MIN:  mode_q <= SET_SEC;
`ifdef CLOCK_ALARM_EN
        SET_SEC:  mode_q <= SET_AHR;
        SET_AHR:  mode_q <= SET_AMIN;
`endif
        default:  mode_q <= RUN;
      endcase
    end
  end

  assign sec_inc = run ? tick      : (btn_inc & (mode_q == SET_SEC));
  assign min_inc = run ? sec_carry : (btn_inc & (mode_q == SET_MIN));
  assign hr_inc  = run ? min_carry : (btn_inc & (mode_q == SET_HR));

  bcd_mod_cnt #(.MAX_TENS(5), .MAX_ONES(9), .MIN_VAL(0), .RST_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .clr(btn_clr), .inc(sec_inc), .cen(run),
    .tens(sec_tens), .ones(sec_ones), .next_tens(sec_ntens), .next_ones(sec_nones),
    .carry(sec_carry)
  );

  bcd_mod_cnt #(.MAX_TENS(5), .MAX_ONES(9), .MIN_VAL(0), .RST_VAL(0)) u_min (
    .clk(clk), .rst(rst), .clr(btn_clr), .inc(min_inc), .cen(run),
    .tens(min_tens), .ones(min_ones), .next_tens(min_ntens), .next_ones(min_nones),
    .carry(min_carry)
  );

  bcd_mod_cnt #(.MAX_TENS(HrMaxT), .MAX_ONES(HrMaxO), .MIN_VAL(HrMin), .RST_VAL(HrRst)) u_hr (
    .clk(clk), .rst(rst), .clr(btn_clr), .inc(hr_inc), .cen(run),
    .tens(hr_tens), .ones(hr_ones), .next_tens(hr_ntens), .next_ones(hr_nones),
    .carry(hr_carry)
  );

  // pm flips whenever the hour steps out of 11, whether by carry or by btn_inc.
  always_ff @(posedge clk) begin
    if (rst || btn_clr || (H24 != 0))                         pm_q <= 1'b0;
    else if (hr_inc && hr_tens == 4'd1 && hr_ones == 4'd1)    pm_q <= ~pm_q;
  end
  assign pm = pm_q;

  logic [3:0] dsp_hr_t, dsp_hr_o, dsp_min_t, dsp_min_o;
  logic       show_alarm;

`ifdef CLOCK_ALARM_EN
  localparam int unsigned AcW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;

  logic [3:0]     ahr_tens, ahr_ones, amin_tens, amin_ones;
  logic [3:0]     ahr_ntens, ahr_nones, amin_ntens, amin_nones;
  logic           ahr_carry, amin_carry, any_btn, match, alarm_q;
  logic [AcW-1:0] acnt_q;

  bcd_mod_cnt #(.MAX_TENS(HrMaxT), .MAX_ONES(HrMaxO), .MIN_VAL(HrMin), .RST_VAL(HrRst)) u_ahr (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(btn_inc & (mode_q == SET_AHR)), .cen(1'b0),
    .tens(ahr_tens), .ones(ahr_ones), .next_tens(ahr_ntens), .next_ones(ahr_nones),
    .carry(ahr_carry)
  );

  bcd_mod_cnt #(.MAX_TENS(5), .MAX_ONES(9), .MIN_VAL(0), .RST_VAL(0)) u_amin (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(btn_inc & (mode_q == SET_AMIN)), .cen(1'b0),
    .tens(amin_tens), .ones(amin_ones), .next_tens(amin_ntens), .next_ones(amin_nones),
    .carry(amin_carry)
  );

  assign any_btn = btn_mode | btn_inc | btn_clr;
  // A seconds carry means the time about to be loaded is hh:mm:00.
  assign match   = run & tick & sec_carry &
                   (hr_ntens == ahr_tens) && (hr_nones == ahr_ones) &&
                   (min_ntens == amin_tens) && (min_nones == amin_ones);

  always_ff @(posedge clk) begin
    if (rst || any_btn) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else if (match) begin
      alarm_q <= 1'b1;
      acnt_q  <= '0;
    end else if (alarm_q && tick) begin
      if (acnt_q == AcW'(ALARM_SEC - 1)) alarm_q <= 1'b0;
      acnt_q <= acnt_q + 1'b1;
    end
  end
  assign alarm = alarm_q;

  assign show_alarm = (mode_q == SET_AHR) || (mode_q == SET_AMIN);
  assign {dsp_hr_t, dsp_hr_o, dsp_min_t, dsp_min_o} = show_alarm ?
         {ahr_tens, ahr_ones, amin_tens, amin_ones} : {hr_tens, hr_ones, min_tens, min_ones};

  logic unused_cnt;
  assign unused_cnt = ^{sec_ntens, sec_nones, hr_carry, ahr_carry, amin_carry,
                        ahr_ntens, ahr_nones, amin_ntens, amin_nones};
`else
  assign alarm      = 1'b0;
  assign show_alarm = 1'b0;
  assign {dsp_hr_t, dsp_hr_o, dsp_min_t, dsp_min_o} = {hr_tens, hr_ones, min_tens, min_ones};

  logic unused_cnt;
  assign unused_cnt = ^{sec_ntens, sec_nones, min_ntens, min_nones, hr_ntens, hr_nones,
                        hr_carry};
`endif

  assign blink = ~run & (presc_q >= PresHalf);

  assign HEX5 = seg7(dsp_hr_t,  blink & ((mode_q == SET_HR)  || (mode_q == SET_AHR)));
  assign HEX4 = seg7(dsp_hr_o,  blink & ((mode_q == SET_HR)  || (mode_q == SET_AHR)));
  assign HEX3 = seg7(dsp_min_t, blink & ((mode_q == SET_MIN) || (mode_q == SET_AMIN)));
  assign HEX2 = seg7(dsp_min_o, blink & ((mode_q == SET_MIN) || (mode_q == SET_AMIN)));
  assign HEX1 = seg7(sec_tens,  show_alarm | (blink & (mode_q == SET_SEC)));
  assign HEX0 = seg7(sec_ones,  show_alarm | (blink & (mode_q == SET_SEC)));

endmodule

// File: tb/tb_clock_hms.sv
// Bench for clock_hms: a 24-h and a 12-h instance, each checked every cycle against a time model.
module tb_clock_hms;

  localparam int unsigned CLK_HZ = 4;
  localparam int          ASEC   = 3;
`ifdef CLOCK_ALARM_EN
  localparam bit AlarmOn = 1'b1;
`else
  localparam bit AlarmOn = 1'b0;
`endif
  localparam int KMode = 0, KInc = 1, KClr = 2, KRst = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, mode_v, inc_v, clr_v;
  logic [6:0] hex_a [6];
  logic [6:0] hex_b [6];
  logic       pm_a, pm_b, alarm_a, alarm_b;

  clock_hms #(.CLK_HZ(CLK_HZ), .H24(1), .ALARM_SEC(ASEC)) dut_a (
    .clk(clk), .rst(rst_v[0]), .btn_mode(mode_v[0]), .btn_inc(inc_v[0]), .btn_clr(clr_v[0]),
    .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]), .HEX3(hex_a[3]), .HEX4(hex_a[4]),
    .HEX5(hex_a[5]), .pm(pm_a), .alarm(alarm_a)
  );

  clock_hms #(.CLK_HZ(CLK_HZ), .H24(0), .ALARM_SEC(ASEC)) dut_b (
    .clk(clk), .rst(rst_v[1]), .btn_mode(mode_v[1]), .btn_inc(inc_v[1]), .btn_clr(clr_v[1]),
    .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]), .HEX3(hex_b[3]), .HEX4(hex_b[4]),
    .HEX5(hex_b[5]), .pm(pm_b), .alarm(alarm_b)
  );

  // mode: 0 run, 1 set hr, 2 set min, 3 set sec, 4 set alarm hr, 5 set alarm min
  typedef struct packed {
    int mode; int hh; int mm; int ss; int pm; int presc;
    int alarm; int acnt; int ahh; int amm;
  } model_t;

  model_t m0, m1;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;

  function automatic model_t reset_model(bit h24);
    model_t n;
    n = '0;
    n.hh  = h24 ? 0 : 12;
    n.ahh = n.hh;
    return n;
  endfunction

  function automatic int next_hour(int h, bit h24);
    if (h24) return (h + 1) % 24;
    return (h == 12) ? 1 : h + 1;
  endfunction

  function automatic model_t step(model_t m, logic r, logic c, logic i, logic b, bit h24);
    model_t n;
    bit     tick;
    n = m;
    if (r) return reset_model(h24);
    tick    = (m.presc == CLK_HZ - 1);
    n.presc = tick ? 0 : m.presc + 1;
    if (c) begin
      n.hh = h24 ? 0 : 12; n.mm = 0; n.ss = 0; n.pm = 0; n.presc = 0;
      n.alarm = 0; n.acnt = 0;
      return n;
    end
    if (m.mode == 0) begin
      if (tick) begin
        n.ss = (m.ss + 1) % 60;
        if (n.ss == 0) begin
          n.mm = (m.mm + 1) % 60;
          if (n.mm == 0) begin
            n.hh = next_hour(m.hh, h24);
            if (!h24 && m.hh == 11) n.pm = 1 - m.pm;
          end
        end
      end
    end else if (i) begin
      case (m.mode)
        1: begin
          n.hh = next_hour(m.hh, h24);
          if (!h24 && m.hh == 11) n.pm = 1 - m.pm;
        end
        2: n.mm  = (m.mm + 1) % 60;
        3: n.ss  = (m.ss + 1) % 60;
        4: n.ahh = next_hour(m.ahh, h24);
        5: n.amm = (m.amm + 1) % 60;
        default: ;
      endcase
    end
    if (b) begin
      if (m.mode == (AlarmOn ? 5 : 3)) begin
        n.mode  = 0;
        n.presc = 0;
      end else begin
        n.mode = m.mode + 1;
      end
    end
    if (AlarmOn) begin
      if (i || b) begin
        n.alarm = 0; n.acnt = 0;
      end else if (m.mode == 0 && tick && n.ss == 0 && n.hh == m.ahh && n.mm == m.amm) begin
        n.alarm = 1; n.acnt = 0;
      end else if (m.alarm != 0 && tick) begin
        n.acnt = m.acnt + 1;
        if (n.acnt == ASEC) n.alarm = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] exp_hex(model_t m, int k);
    int hh, mm, v, field;
    bit aview, blink;
    aview = (m.mode >= 4);
    hh    = aview ? m.ahh : m.hh;
    mm    = aview ? m.amm : m.mm;
    blink = (m.mode != 0) && (m.presc >= CLK_HZ / 2);
    field = (m.mode == 1 || m.mode == 4) ? 2 : (m.mode == 2 || m.mode == 5) ? 1 :
            (m.mode == 3) ? 0 : -1;
    if (aview && k < 2) return 7'h7F;
    if (blink && field == k / 2) return 7'h7F;
    case (k)
      0: v = m.ss % 10;
      1: v = m.ss / 10;
      2: v = mm % 10;
      3: v = mm / 10;
      4: v = hh % 10;
      default: v = hh / 10;
    endcase
    return seg_tab[v];
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    m0 <= step(m0, rst_v[0], clr_v[0], inc_v[0], mode_v[0], 1'b1);
    m1 <= step(m1, rst_v[1], clr_v[1], inc_v[1], mode_v[1], 1'b0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("model_a_hex%0d", k), hex_a[k], exp_hex(m0, k));
        check($sformatf("model_b_hex%0d", k), hex_b[k], exp_hex(m1, k));
      end
      check("model_a_pm", {6'd0, pm_a}, 7'(m0.pm));
      check("model_b_pm", {6'd0, pm_b}, 7'(m1.pm));
      check("model_a_alarm", {6'd0, alarm_a}, 7'(m0.alarm));
      check("model_b_alarm", {6'd0, alarm_b}, 7'(m1.alarm));
    end
  end

  // Each pulse holds for one clock and returns on the following falling edge.
  task automatic pulse(input int d, input int kind, input int n);
    repeat (n) begin
      case (kind)
        KMode:   mode_v[d] = 1'b1;
        KInc:    inc_v[d]  = 1'b1;
        KClr:    clr_v[d]  = 1'b1;
        default: rst_v[d]  = 1'b1;
      endcase
      @(negedge clk);
      mode_v[d] = 1'b0; inc_v[d] = 1'b0; clr_v[d] = 1'b0; rst_v[d] = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_v = '1; mode_v = '0; inc_v = '0; clr_v = '0;
    cyc(2);
    rst_v  = '0;
    chk_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rst_a_hex%0d", k), hex_a[k], 7'h40);
      check($sformatf("rst_b_hex%0d", k), hex_b[k], (k == 5) ? 7'h79 : (k == 4) ? 7'h24 : 7'h40);
    end
    check("rst_b_pm", {6'd0, pm_b}, 7'h00);
    check("rst_a_alarm", {6'd0, alarm_a}, 7'h00);

    // 240 cycles = 60 ticks -> 00:01:00
    cyc(240);
    check("one_min_hex2", hex_a[2], 7'h79);
    check("one_min_hex0", hex_a[0], 7'h40);
    check("one_min_hex4", hex_a[4], 7'h40);

    // Hours set to 03 from a cleared clock; prescaler is 0 here.
    pulse(0, KClr, 1);
    pulse(0, KMode, 1);
    pulse(0, KInc, 3);
    check("set_hr_hex4", hex_a[4], 7'h30);
    check("set_hr_hex5", hex_a[5], 7'h40);
    cyc(2);
    check("blink_hex4", hex_a[4], 7'h7F);
    check("blink_hex5", hex_a[5], 7'h7F);
    cyc(6);
    check("frozen_hex0", hex_a[0], 7'h40);
    pulse(0, KMode, 3);
    cyc(3);
    check("exit_no_tick", hex_a[0], 7'h40);
    cyc(1);
    check("exit_tick4", hex_a[0], 7'h79);

    // SET_MIN wrap 59 -> 00 leaves hours alone, then clr beats inc.
    pulse(0, KMode, 2);
    pulse(0, KInc, 60);
    check("min_wrap_hr", hex_a[4], 7'h30);
    clr_v[0] = 1'b1; inc_v[0] = 1'b1;
    cyc(1);
    clr_v[0] = 1'b0; inc_v[0] = 1'b0;
    check("clr_inc_hr", hex_a[4], 7'h40);
    check("clr_inc_sec", hex_a[0], 7'h40);
    pulse(0, KMode, 2);

    // Tick coincident with clr.
    cyc(20);
    check("five_sec", hex_a[0], 7'h12);
    cyc(3);
    pulse(0, KClr, 1);
    check("tick_clr", hex_a[0], 7'h40);

    // Reset from the middle of SET_SEC returns to RUN with reset time.
    pulse(0, KMode, 3);
    pulse(0, KInc, 5);
    pulse(0, KRst, 1);
    check("rst_set_sec", hex_a[0], 7'h40);
    cyc(4);
    check("rst_run_tick", hex_a[0], 7'h79);

    // 23:59:59 -> 00:00:00, then one hour of running.
    pulse(0, KMode, 1); pulse(0, KInc, 23);
    pulse(0, KMode, 1); pulse(0, KInc, 59);
    pulse(0, KMode, 1); pulse(0, KInc, 58);
    pulse(0, KMode, 1);
    cyc(3);
    check("pre_day_hex5", hex_a[5], 7'h24);
    check("pre_day_hex4", hex_a[4], 7'h30);
    cyc(1);
    for (int k = 0; k < 6; k++) check($sformatf("day_wrap_hex%0d", k), hex_a[k], 7'h40);
    cyc(14400);
    check("hour_hex4", hex_a[4], 7'h79);
    check("hour_hex2", hex_a[2], 7'h40);

    // 12-h: 11:59:59 -> 12:00:00 pm, 12:59:59 -> 01:00:00 pm kept.
    pulse(1, KClr, 1);
    pulse(1, KMode, 1); pulse(1, KInc, 11);
    pulse(1, KMode, 1); pulse(1, KInc, 59);
    pulse(1, KMode, 1); pulse(1, KInc, 59);
    pulse(1, KMode, 1);
    cyc(3);
    check("h12_pre_hex4", hex_b[4], 7'h79);
    check("h12_pre_pm", {6'd0, pm_b}, 7'h00);
    cyc(1);
    check("h12_noon_hex5", hex_b[5], 7'h79);
    check("h12_noon_hex4", hex_b[4], 7'h24);
    check("h12_noon_pm", {6'd0, pm_b}, 7'h01);
    pulse(1, KMode, 2); pulse(1, KInc, 59);
    pulse(1, KMode, 1); pulse(1, KInc, 59);
    pulse(1, KMode, 1);
    cyc(4);
    check("h12_one_hex5", hex_b[5], 7'h40);
    check("h12_one_hex4", hex_b[4], 7'h79);
    check("h12_one_pm", {6'd0, pm_b}, 7'h01);

`ifdef CLOCK_ALARM_EN
    // Alarm at 00:02 on the 24-h instance.
    pulse(0, KMode, 5);
    pulse(0, KInc, 2);
    pulse(0, KMode, 1);
    pulse(0, KClr, 1);
    cyc(479);
    check("alarm_before", {6'd0, alarm_a}, 7'h00);
    cyc(1);
    check("alarm_rise", {6'd0, alarm_a}, 7'h01);
    check("alarm_rise_min", hex_a[2], 7'h24);
    cyc(11);
    check("alarm_hold", {6'd0, alarm_a}, 7'h01);
    cyc(1);
    check("alarm_fall", {6'd0, alarm_a}, 7'h00);
    pulse(0, KClr, 1);
    cyc(480);
    check("alarm_rerun", {6'd0, alarm_a}, 7'h01);
    pulse(0, KInc, 1);
    check("alarm_btn_clear", {6'd0, alarm_a}, 7'h00);
`else
    check("alarm_tied_a", {6'd0, alarm_a}, 7'h00);
    check("alarm_tied_b", {6'd0, alarm_b}, 7'h00);
`endif

    cyc(8);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
